// File: rtl/i2s_tx_fifo.sv
// ----------------------------------------------------------------------------
// i2s_tx_fifo
// Two-entry word FIFO that holds samples waiting for the I2S serializer.
//
// Ports
//   clk_i    : clock, all logic on the rising edge
//   rst_i    : synchronous active-low reset
//   flush_i  : empties the FIFO (wins over push/pop)
//   push_i   : store data_i; ignored while full_o=1
//   pop_i    : advance past the head entry; ignored while empty_o=1
//   data_i   : word to store
//   head_o   : oldest stored word (meaningful only while empty_o=0)
//   empty_o  : no entries stored
//   full_o   : both entries occupied
// ----------------------------------------------------------------------------
module i2s_tx_fifo #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    output logic [WORD_WIDTH-1:0] head_o,
    output logic                  empty_o,
    output logic                  full_o
);

    logic [WORD_WIDTH-1:0] r_mem [2];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_count;
    logic                  w_push;
    logic                  w_pop;

    assign full_o  = (r_count == 2'd2);
    assign empty_o = (r_count == 2'd0);
    assign w_push  = push_i & ~full_o & ~flush_i;
    assign w_pop   = pop_i & ~empty_o & ~flush_i;
    assign head_o  = r_mem[r_rd_ptr];

    // Storage carries no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/i2s_top_tx.sv
// ----------------------------------------------------------------------------
// i2s_top_tx
// I2S transmitter: queues sample words in a 2-entry FIFO and serializes them
// MSB first, left then right, with word select leading the MSB by one bit.
//
// Ports
//   clk_i          : clock, all logic on the rising edge
//   rst_i          : synchronous active-low reset
//   en_i           : transmit enable; dropping it abandons the frame
//   data_i         : sample word to queue
//   write_i        : push data_i (taken only while ready_o=1)
//   ready_o        : FIFO not full
//   lr_chnl_o      : channel of the next accepted word (0=left, 1=right)
//   underrun_o     : sticky, set when a word had to be sent from an empty FIFO
//   underrun_clr_i : clears underrun_o (a simultaneous set wins)
//   sclk_o         : bit clock, period 2*CLK_DIV clk_i cycles
//   wsel_o         : word select (0=left)
//   sdat_o         : serial data, changes with sclk_o falling
//
// State table
//   state   | meaning
//   S_IDLE  | outputs low, writes accepted to prefill the FIFO
//   S_START | one sclk period carrying a dummy 0 bit with wsel_o=0
//   S_RUN   | continuous left/right word stream
// ----------------------------------------------------------------------------
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module i2s_top_tx #(
    parameter int WORD_WIDTH = 16,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    input  logic                  write_i,
    output logic                  ready_o,
    output logic                  lr_chnl_o,
    output logic                  underrun_o,
    input  logic                  underrun_clr_i,
    output logic                  sclk_o,
    output logic                  wsel_o,
    output logic                  sdat_o
);

    localparam int BW = `CLOG2(WORD_WIDTH);
    localparam int DW = `CLOG2(CLK_DIV + 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WORD_WIDTH - 1);
    localparam logic [BW-1:0] BIT_PENULT = BW'(WORD_WIDTH - 2);
    localparam logic [DW-1:0] DIV_LOAD   = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DW-1:0]         r_div_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [WORD_WIDTH-1:0] r_shift;
    logic                  r_sclk;
    logic                  r_wsel;
    logic                  r_sdat;
    logic                  r_lr_chnl;
    logic                  r_underrun;

    logic                  w_tick;
    logic                  w_fall;
    logic                  w_pop;
    logic                  w_abort;
    logic                  w_lsb;
    logic                  w_accept;
    logic                  w_empty;
    logic                  w_full;
    logic [WORD_WIDTH-1:0] w_head;
    logic [WORD_WIDTH-1:0] w_word;

    i2s_tx_fifo #(.WORD_WIDTH(WORD_WIDTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (w_abort),
        .push_i  (write_i),
        .pop_i   (w_pop),
        .data_i  (data_i),
        .head_o  (w_head),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

    assign w_tick   = (r_state != S_IDLE) && (r_div_cnt == '0);
    assign w_fall   = w_tick & r_sclk;
    assign w_accept = write_i & ~w_full & ~w_abort;
    // An empty FIFO at the pop tick sends a word of zeros.
    assign w_word   = w_empty ? '0 : w_head;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_abort      = 1'b0;
        w_lsb        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en_i) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (!en_i) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_fall) begin
                    w_pop        = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (!en_i) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_fall) begin
                    w_pop = (r_bit_cnt == BIT_LAST);
                    w_lsb = (r_bit_cnt == BIT_PENULT);
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Divider, shifter and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i || (r_state == S_IDLE) || w_abort) begin
            r_div_cnt <= DIV_LOAD;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_sclk    <= 1'b0;
            r_wsel    <= 1'b0;
            r_sdat    <= 1'b0;
        end else begin
            if (w_tick) begin
                r_sclk    <= ~r_sclk;
                r_div_cnt <= DIV_LOAD;
            end else begin
                r_div_cnt <= r_div_cnt - DW'(1);
            end
            if (w_fall) begin
                if (w_pop) begin
                    r_sdat    <= w_word[WORD_WIDTH-1];
                    r_shift   <= {w_word[WORD_WIDTH-2:0], 1'b0};
                    r_bit_cnt <= '0;
                end else begin
                    r_sdat    <= r_shift[WORD_WIDTH-1];
                    r_shift   <= {r_shift[WORD_WIDTH-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + BW'(1);
                end
                if (w_lsb) begin
                    r_wsel <= ~r_wsel;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i || w_abort) begin
            r_lr_chnl <= 1'b0;
        end else if (w_accept) begin
            r_lr_chnl <= ~r_lr_chnl;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_underrun <= 1'b0;
        end else if (w_pop && w_empty) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr_i) begin
            r_underrun <= 1'b0;
        end
    end

    assign ready_o    = ~w_full;
    assign lr_chnl_o  = r_lr_chnl;
    assign underrun_o = r_underrun;
    assign sclk_o     = r_sclk;
    assign wsel_o     = r_wsel;
    assign sdat_o     = r_sdat;

endmodule

// File: tb/tb_i2s_top_tx.sv
// ----------------------------------------------------------------------------
// tb_i2s_top_tx
// Directed bench for i2s_top_tx (WORD_WIDTH=16, CLK_DIV=2). A receiver-side
// sampler records sdat_o/wsel_o at every sclk_o rising edge; expected bit
// streams are written out by hand.
// ----------------------------------------------------------------------------
module tb_i2s_top_tx;

    localparam int W  = 16;
    localparam int CD = 2;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         en_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic         write_i = 1'b0;
    logic         underrun_clr_i = 1'b0;
    logic         ready_o;
    logic         lr_chnl_o;
    logic         underrun_o;
    logic         sclk_o;
    logic         wsel_o;
    logic         sdat_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   cap_on   = 1'b0;
    logic prev_sclk = 1'b0;
    logic cap_sdat[$];
    logic cap_ws[$];
    int   cap_t[$];
    int   t_en;

    logic [W-1:0] stream_words [8] = '{16'h1234, 16'hABCD, 16'h8001, 16'h7FFE,
                                       16'hFFFF, 16'h5A5A, 16'hC33C, 16'h0001};

    i2s_top_tx #(.WORD_WIDTH(W), .CLK_DIV(CD)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .data_i         (data_i),
        .write_i        (write_i),
        .ready_o        (ready_o),
        .lr_chnl_o      (lr_chnl_o),
        .underrun_o     (underrun_o),
        .underrun_clr_i (underrun_clr_i),
        .sclk_o         (sclk_o),
        .wsel_o         (wsel_o),
        .sdat_o         (sdat_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    always @(posedge clk_i) begin
        #1;
        if (cap_on && sclk_o && !prev_sclk) begin
            cap_sdat.push_back(sdat_o);
            cap_ws.push_back(wsel_o);
            cap_t.push_back(cyc);
        end
        prev_sclk = sclk_o;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic push_word(input logic [W-1:0] d);
        data_i  = d;
        write_i = 1'b1;
        @(negedge clk_i);
        write_i = 1'b0;
    endtask

    task automatic clr_underrun();
        underrun_clr_i = 1'b1;
        @(negedge clk_i);
        underrun_clr_i = 1'b0;
    endtask

    task automatic start_tx();
        cap_sdat.delete();
        cap_ws.delete();
        cap_t.delete();
        prev_sclk = sclk_o;
        cap_on    = 1'b1;
        t_en      = cyc;
        en_i      = 1'b1;
    endtask

    task automatic stop_tx();
        en_i = 1'b0;
        wait_cyc(2);
        cap_on = 1'b0;
    endtask

    task automatic wait_bits(input int n, input string tag);
        int b;
        b = 0;
        while (cap_sdat.size() < n && b < 5000) begin
            @(negedge clk_i);
            b++;
        end
        chk({tag, "_bitcount"}, 64'(cap_sdat.size() >= n), 64'd1);
    endtask

    function automatic logic [63:0] pack_sdat(input int start, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[62:0], cap_sdat[start+i]};
        return v;
    endfunction

    function automatic logic [63:0] pack_ws(input int start, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[62:0], cap_ws[start+i]};
        return v;
    endfunction

    initial begin
        // ---- reset state
        wait_cyc(3);
        chk("rst_ready",    ready_o,    1);
        chk("rst_lr",       lr_chnl_o,  0);
        chk("rst_underrun", underrun_o, 0);
        chk("rst_sclk",     sclk_o,     0);
        chk("rst_wsel",     wsel_o,     0);
        chk("rst_sdat",     sdat_o,     0);
        rst_i = 1'b1;
        wait_cyc(2);

        // ---- prefill L/R, basic frame
        push_word(16'hA5A5);
        chk("pre_lr1", lr_chnl_o, 1);
        push_word(16'h0F0F);
        chk("pre_lr0", lr_chnl_o, 0);
        chk("pre_full", ready_o, 0);
        chk("idle_sclk", sclk_o, 0);
        start_tx();
        wait_bits(33, "frame");
        chk("frame_first_rise", 64'(cap_t[0] - t_en), 3);
        chk("frame_period", 64'(cap_t[1] - cap_t[0]), 2 * CD);
        chk("frame_sdat", pack_sdat(0, 33), {31'h0, 1'b0, 16'hA5A5, 16'h0F0F});
        chk("frame_wsel", pack_ws(0, 33), {31'h0, 1'b0, 15'h0000, 1'b1, 15'h7FFF, 1'b0});
        chk("frame_no_underrun", underrun_o, 0);
        stop_tx();
        clr_underrun();

        // ---- no data: zeros and sticky underrun
        start_tx();
        wait_bits(1, "udr_dummy");
        chk("udr_before_pop", underrun_o, 0);
        wait_bits(17, "udr");
        chk("udr_set", underrun_o, 1);
        chk("udr_zero_word", pack_sdat(1, 16), 0);
        stop_tx();
        chk("udr_sticky", underrun_o, 1);
        clr_underrun();
        chk("udr_cleared", underrun_o, 0);

        // ---- streaming 8 words
        start_tx();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    int b;
                    b = 0;
                    while (!ready_o && b < 2000) begin
                        @(negedge clk_i);
                        b++;
                    end
                    chk($sformatf("stream_ready%0d", i), ready_o, 1);
                    chk($sformatf("stream_lr%0d", i), lr_chnl_o, 64'(i % 2));
                    push_word(stream_words[i]);
                end
            end
            wait_bits(1 + 8 * W, "stream");
        join
        for (int i = 0; i < 8; i++)
            chk($sformatf("stream_word%0d", i), pack_sdat(1 + i * W, W), 64'(stream_words[i]));
        chk("stream_no_underrun", underrun_o, 0);
        stop_tx();
        clr_underrun();

        // ---- third write while full is ignored
        push_word(16'hC001);
        push_word(16'h4E02);
        push_word(16'hDEAD);
        chk("full_ready", ready_o, 0);
        chk("full_lr", lr_chnl_o, 0);
        start_tx();
        wait_bits(33, "full");
        chk("full_words", pack_sdat(1, 32), {16'hC001, 16'h4E02});
        stop_tx();
        clr_underrun();

        // ---- en_i dropped mid right word, then flushed FIFO check
        push_word(16'h1111);
        push_word(16'h2222);
        start_tx();
        wait_bits(20, "drop_a");
        push_word(16'h3333);
        wait_bits(26, "drop_b");
        chk("drop_pre_wsel", wsel_o, 1);
        chk("drop_pre_lr", lr_chnl_o, 1);
        en_i = 1'b0;
        @(negedge clk_i);
        chk("drop_sclk",  sclk_o,    0);
        chk("drop_wsel",  wsel_o,    0);
        chk("drop_sdat",  sdat_o,    0);
        chk("drop_ready", ready_o,   1);
        chk("drop_lr",    lr_chnl_o, 0);
        wait_cyc(3);
        clr_underrun();
        start_tx();
        wait_bits(17, "flush");
        chk("flush_zero_word", pack_sdat(1, 16), 0);
        chk("flush_underrun", underrun_o, 1);
        stop_tx();
        clr_underrun();

        // ---- reset during RUN
        push_word(16'h9999);
        start_tx();
        wait_bits(20, "rrun");
        push_word(16'hBEEF);
        push_word(16'hCAFE);
        chk("rrun_pre_underrun", underrun_o, 1);
        chk("rrun_pre_ready", ready_o, 0);
        chk("rrun_pre_lr", lr_chnl_o, 1);
        rst_i   = 1'b0;
        write_i = 1'b1;
        underrun_clr_i = 1'b0;
        @(negedge clk_i);
        chk("rrun_ready",    ready_o,    1);
        chk("rrun_lr",       lr_chnl_o,  0);
        chk("rrun_underrun", underrun_o, 0);
        chk("rrun_sclk",     sclk_o,     0);
        chk("rrun_wsel",     wsel_o,     0);
        chk("rrun_sdat",     sdat_o,     0);
        rst_i   = 1'b1;
        write_i = 1'b0;
        en_i    = 1'b0;
        cap_on  = 1'b0;
        wait_cyc(2);
        push_word(16'h6C6C);
        start_tx();
        wait_bits(17, "restart");
        chk("restart_first_rise", 64'(cap_t[0] - t_en), 3);
        chk("restart_dummy", cap_sdat[0], 0);
        chk("restart_word", pack_sdat(1, 16), 16'h6C6C);
        stop_tx();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
